life_gen_engine: RTL and testbench
==================================

Name: life_gen_engine

Overview:
- Sequential Game-of-Life generation engine sitting directly upstream of the VGA board renderer.
- Holds the authoritative board and, once every FRAMES_PER_GEN frames, computes the next generation one cell per clock into a shadow buffer.
- Commits the new generation atomically, so the renderer never sees a half-updated board.
- Replaces the combinational all-cells update, reducing logic to one shared neighbour evaluator.

Parameters:
- BIT_WIDTH, 3, log2 of board width in cells.
- BIT_HEIGHT, 3, log2 of board height in cells.
- FRAMES_PER_GEN, 60, frame_tick pulses per generation; valid range 1..255.
- SEED, 64'h0000_0000_1C00_0000, board loaded on reset/clear; width is SIZE bits.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse per frame (vsync edge, detected upstream).
- run  input  1  level; high allows generations to advance.
- clear  input  1  one-cycle pulse; reloads SEED.
- board_out  output  SIZE  committed board; bit index = row*BOARD_WIDTH + col.
- busy  output  1  high while a generation is being computed.
- gen_done  output  1  one-cycle pulse in the cycle board_out takes the new generation.
- generation  output  16  generation count since reset/clear; wraps at 16'hFFFF->0.

Behaviour:
- Derived widths: BOARD_WIDTH = 2**BIT_WIDTH, SIZE = BOARD_WIDTH * 2**BIT_HEIGHT.
- Reset values: board_out = SEED, busy = 0, gen_done = 0, generation = 0, frame counter = 0, state = IDLE.
- Frame counter:
  - Increments on frame_tick only while run = 1; holds when run = 0.
  - On a tick at FRAMES_PER_GEN-1 the counter wraps to 0 and a start request is raised.
  - A start request arriving while busy is dropped; no queueing.
- FSM, IDLE:
  - Start request -> SCAN, cell index = 0, busy = 1 from the next cycle.
- FSM, SCAN:
  - Each cycle evaluates cell index from board_out (never from the shadow) and writes the result to shadow[index].
  - Live cell survives on 2 or 3 neighbours; dead cell is born on exactly 3.
  - Neighbour count is 4 bits, 0..8.
  - After index = SIZE-1 -> COMMIT. SCAN lasts exactly SIZE cycles.
- FSM, COMMIT:
  - board_out <= shadow, gen_done = 1, generation += 1, busy = 0 -> IDLE.
  - Latency from the frame_tick cycle to board_out update is SIZE+2 cycles (66 at default).
- Edges: cells outside the board read as dead (no wrap). Row/col are derived from index by bit slicing, not division.
- run deasserted during SCAN: the scan completes and commits.
- clear:
  - Any state -> IDLE, board_out = SEED, generation = 0, frame counter = 0, busy = 0, no gen_done.
  - An in-flight scan is discarded.
  - clear together with frame_tick: clear wins and the tick is ignored.
- board_out changes only in COMMIT, clear, or reset cycles.

Optional Feature:
- Macro LIFE_TORUS_EN.
- Defined: neighbour coordinates wrap modulo board width/height (toroidal board). Wrap is achieved naturally by BIT_WIDTH/BIT_HEIGHT-bit truncation.
- Undefined: out-of-range neighbours count as dead.
- All other timing is identical in both modes.

Decomposition:
- Package life_pkg:
  - BIT_WIDTH, BIT_HEIGHT, BOARD_WIDTH, BOARD_HEIGHT, SIZE.
  - Default seed constant.
  - FSM state encoding IDLE/SCAN/COMMIT (2 bits).
- Sub-module life_cell_eval (combinational):
  - Inputs: board vector, row, col. Outputs: 4-bit neighbour count and next-state bit.
  - Contains the edge/torus handling.
- The engine holds the FSM, counters and both buffers.

Test Plan:
- Blinker: SEED 64'h1C000000, run=1, FRAMES_PER_GEN=1, one tick -> busy high for 64 cycles, gen_done at tick+66, board_out = 64'h0000_0008_0808_0000, generation = 1. A second tick returns 64'h1C000000, generation = 2.
- Still life: SEED 64'h0303 (2x2 block in corner), 10 generations -> board_out constant at 64'h0303, generation = 10.
- Edge semantics: SEED with bits 0, 7, 56, 63 set, one generation -> board_out = 0 without LIFE_TORUS_EN; unchanged with LIFE_TORUS_EN (block across corners).
- Pacing: FRAMES_PER_GEN=60, run=1, 180 ticks -> exactly 3 gen_done pulses, each following the 60th, 120th and 180th tick. With run=0, 100 ticks -> no gen_done, frame counter held.
- Clear mid-scan: pulse clear 20 cycles into SCAN -> next cycle busy = 0, board_out = SEED, generation = 0, no gen_done. clear and frame_tick in the same cycle -> no scan starts.
- Reset mid-scan: assert reset during SCAN -> all outputs at reset values in the following cycle.

Source files
------------

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared board geometry, default seed and FSM encoding for the life engine
package life_pkg;
    localparam int BIT_WIDTH    = 3;
    localparam int BIT_HEIGHT   = 3;
    localparam int BOARD_WIDTH  = 2 ** BIT_WIDTH;
    localparam int BOARD_HEIGHT = 2 ** BIT_HEIGHT;
    localparam int SIZE         = BOARD_WIDTH * BOARD_HEIGHT;

    localparam logic [SIZE-1:0] DEFAULT_SEED = 64'h0000_0000_1C00_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;
endpackage

// File: rtl/life_gen_engine_if.sv
// rtl/life_gen_engine_if.sv - control inputs and committed-board outputs of the life engine
interface life_gen_engine_if #(
    parameter int SIZE = life_pkg::SIZE
);
    logic            frame_tick;
    logic            run;
    logic            clear;
    logic [SIZE-1:0] board_out;
    logic            busy;
    logic            gen_done;
    logic [15:0]     generation;

    modport master (
        output frame_tick, run, clear,
        input  board_out, busy, gen_done, generation
    );

    modport slave (
        input  frame_tick, run, clear,
        output board_out, busy, gen_done, generation
    );
endinterface

// File: rtl/life_cell_eval.sv
// rtl/life_cell_eval.sv - combinational neighbour count and next state for one cell
// Edge handling: dead border by default, toroidal wrap when LIFE_TORUS_EN is defined.
module life_cell_eval #(
    parameter int BIT_WIDTH  = life_pkg::BIT_WIDTH,
    parameter int BIT_HEIGHT = life_pkg::BIT_HEIGHT
) (
    input  logic [(2**(BIT_WIDTH+BIT_HEIGHT))-1:0] board,
    input  logic [BIT_HEIGHT-1:0]                  row,
    input  logic [BIT_WIDTH-1:0]                   col,
    output logic [3:0]                             count,
    output logic                                   next_cell
);
    localparam int BOARD_WIDTH  = 2 ** BIT_WIDTH;
    localparam int BOARD_HEIGHT = 2 ** BIT_HEIGHT;

    logic [BIT_HEIGHT-1:0] nr;
    logic [BIT_WIDTH-1:0]  nc;
    logic                  in_range;

    always_comb begin
        count    = '0;
        nr       = '0;
        nc       = '0;
        in_range = 1'b0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                // Truncation to the coordinate width is what makes the torus wrap.
                nr = BIT_HEIGHT'(int'(row) + dr - 1);
                nc = BIT_WIDTH'(int'(col) + dc - 1);
`ifdef LIFE_TORUS_EN
                in_range = 1'b1;
`else
                in_range = (int'(row) + dr - 1 >= 0) && (int'(row) + dr - 1 < BOARD_HEIGHT) &&
                           (int'(col) + dc - 1 >= 0) && (int'(col) + dc - 1 < BOARD_WIDTH);
`endif
                if (!(dr == 1 && dc == 1) && in_range && board[{nr, nc}])
                    count = count + 4'd1;
            end
        end
        next_cell = board[{row, col}] ? (count == 4'd2 || count == 4'd3) : (count == 4'd3);
    end
endmodule

// File: rtl/life_gen_engine.sv
// rtl/life_gen_engine.sv - sequential Game-of-Life engine, one cell per clock into a shadow buffer
// Optional toroidal board via LIFE_TORUS_EN (handled in life_cell_eval).
module life_gen_engine #(
    parameter int BIT_WIDTH      = life_pkg::BIT_WIDTH,
    parameter int BIT_HEIGHT     = life_pkg::BIT_HEIGHT,
    parameter int FRAMES_PER_GEN = 60,
    parameter logic [(2**(BIT_WIDTH+BIT_HEIGHT))-1:0] SEED = life_pkg::DEFAULT_SEED
) (
    input logic               clk,
    input logic               reset,
    life_gen_engine_if.slave  bus
);
    localparam int IDX_W = BIT_WIDTH + BIT_HEIGHT;
    localparam int SIZE  = 2 ** IDX_W;
    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

    import life_pkg::*;

    state_t            state, next_state;
    logic [IDX_W-1:0]  index;
    logic [SIZE-1:0]   board;
    logic [SIZE-1:0]   shadow;
    logic [7:0]        frame_cnt;
    logic [15:0]       gen_cnt;
    logic              done;
    logic              start_req;
    logic              next_cell;
    logic [3:0]        count;
    logic              unused_count;

    assign start_req    = bus.frame_tick && bus.run && !bus.clear && (frame_cnt == LAST_FRAME);
    assign unused_count = ^count;

    life_cell_eval #(
        .BIT_WIDTH  (BIT_WIDTH),
        .BIT_HEIGHT (BIT_HEIGHT)
    ) u_eval (
        .board     (board),
        .row       (index[IDX_W-1:BIT_WIDTH]),
        .col       (index[BIT_WIDTH-1:0]),
        .count     (count),
        .next_cell (next_cell)
    );

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            state     <= IDLE;
            index     <= '0;
            board     <= SEED;
            frame_cnt <= '0;
            gen_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            // The frame counter keeps pacing even while busy; a start landing mid-scan is simply lost.
            if (bus.frame_tick && bus.run)
                frame_cnt <= (frame_cnt == LAST_FRAME) ? 8'd0 : frame_cnt + 8'd1;
            case (state)
                IDLE: index <= '0;
                SCAN: begin
                    shadow[index] <= next_cell;
                    index         <= index + 1'b1;
                end
                COMMIT: begin
                    board   <= shadow;
                    done    <= 1'b1;
                    gen_cnt <= gen_cnt + 16'd1;
                end
                default: index <= '0;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_req) next_state = SCAN;
            SCAN:    if (index == IDX_W'(SIZE - 1)) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.board_out  = board;
    assign bus.busy       = (state == SCAN);
    assign bus.gen_done   = done;
    assign bus.generation = gen_cnt;
endmodule

// File: tb/tb_life_gen_engine.sv
// tb/tb_life_gen_engine.sv - directed and randomized checks of life_gen_engine against a board-level model
module tb_life_gen_engine;
    localparam logic [63:0] SEED_BLINK  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] SEED_BLOCK  = 64'h0000_0000_0000_0303;
    localparam logic [63:0] SEED_CORNER = 64'h8100_0000_0000_0081;
    localparam logic [63:0] SEED_RAND   = 64'h3C5A_9E17_B2D4_0F68;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_a = 1'b0, run_a = 1'b0, clear_a = 1'b0;
    logic tick_p = 1'b0, run_p = 1'b0, clear_p = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [63:0] model [4];
    logic [63:0] seeds [4];
    int gen_a = 0;
    int p_dones = 0;
    int p_misplaced = 0;

    always #5 clk = ~clk;

    life_gen_engine_if #(.SIZE(64)) if_blink ();
    life_gen_engine_if #(.SIZE(64)) if_block ();
    life_gen_engine_if #(.SIZE(64)) if_corner ();
    life_gen_engine_if #(.SIZE(64)) if_rand ();
    life_gen_engine_if #(.SIZE(64)) if_pace ();

    assign if_blink.frame_tick  = tick_a;  assign if_blink.run  = run_a;  assign if_blink.clear  = clear_a;
    assign if_block.frame_tick  = tick_a;  assign if_block.run  = run_a;  assign if_block.clear  = clear_a;
    assign if_corner.frame_tick = tick_a;  assign if_corner.run = run_a;  assign if_corner.clear = clear_a;
    assign if_rand.frame_tick   = tick_a;  assign if_rand.run   = run_a;  assign if_rand.clear   = clear_a;
    assign if_pace.frame_tick   = tick_p;  assign if_pace.run   = run_p;  assign if_pace.clear   = clear_p;

    life_gen_engine #(.FRAMES_PER_GEN(1), .SEED(SEED_BLINK))  u_blink  (.clk(clk), .reset(reset), .bus(if_blink));
    life_gen_engine #(.FRAMES_PER_GEN(1), .SEED(SEED_BLOCK))  u_block  (.clk(clk), .reset(reset), .bus(if_block));
    life_gen_engine #(.FRAMES_PER_GEN(1), .SEED(SEED_CORNER)) u_corner (.clk(clk), .reset(reset), .bus(if_corner));
    life_gen_engine #(.FRAMES_PER_GEN(1), .SEED(SEED_RAND))   u_rand   (.clk(clk), .reset(reset), .bus(if_rand));
    life_gen_engine #(.FRAMES_PER_GEN(60))                    u_pace   (.clk(clk), .reset(reset), .bus(if_pace));

    // Reference: plain 8x8 grid arithmetic over all eight neighbours of every cell.
    function automatic logic [63:0] life_step(input logic [63:0] b);
        logic [63:0] nb;
        nb = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
`ifdef LIFE_TORUS_EN
                        rr = (rr + 8) % 8;
                        cc = (cc + 8) % 8;
`endif
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            n += int'(b[rr*8+cc]);
                    end
                end
                nb[r*8+c] = (n == 3) || (b[r*8+c] && n == 2);
            end
        end
        return nb;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_boards(input string tag);
        chk({tag, " blink board"},  if_blink.board_out,  model[0]);
        chk({tag, " block board"},  if_block.board_out,  model[1]);
        chk({tag, " corner board"}, if_corner.board_out, model[2]);
        chk({tag, " rand board"},   if_rand.board_out,   model[3]);
        chk({tag, " blink gen"},    64'(if_blink.generation), 64'(gen_a));
        chk({tag, " rand gen"},     64'(if_rand.generation),  64'(gen_a));
    endtask

    task automatic reset_models();
        for (int i = 0; i < 4; i++) model[i] = seeds[i];
        gen_a = 0;
    endtask

    // One frame tick on group A, optional extra tick mid-scan, then ~68 cycles of observation.
    task automatic gen_a_step(input string tag, input bit run_val, input int extra_at);
        int busy_n;
        int done_at;
        int done_n;
        busy_n = 0;
        done_at = 0;
        done_n = 0;
        run_a = run_val;
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        for (int k = 1; k <= 68; k++) begin
            if (if_blink.busy) busy_n++;
            if (if_rand.gen_done) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
            tick_a = (k == extra_at);
            step();
        end
        tick_a = 1'b0;
        if (run_val) begin
            for (int i = 0; i < 4; i++) model[i] = life_step(model[i]);
            gen_a = (gen_a + 1) % 65536;
        end
        chk({tag, " busy cycles"}, 64'(busy_n), run_val ? 64'd64 : 64'd0);
        chk({tag, " gen_done cycle"}, 64'(done_at), run_val ? 64'd66 : 64'd0);
        chk({tag, " gen_done pulses"}, 64'(done_n), run_val ? 64'd1 : 64'd0);
        check_boards(tag);
    endtask

    task automatic pace_ticks(input bit run_val, input int n, input int gen_every);
        run_p = run_val;
        for (int t = 1; t <= n; t++) begin
            tick_p = 1'b1;
            step();
            tick_p = 1'b0;
            for (int k = 1; k <= 69; k++) begin
                if (if_pace.gen_done) begin
                    p_dones++;
                    if (gen_every == 0 || (t % gen_every) != 0 || k != 66) p_misplaced++;
                end
                step();
            end
        end
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, " busy"},     64'(if_blink.busy),       64'd0);
        chk({tag, " gen_done"}, 64'(if_blink.gen_done),   64'd0);
        chk({tag, " gen"},      64'(if_blink.generation), 64'd0);
        chk({tag, " blink"},    if_blink.board_out,       SEED_BLINK);
        chk({tag, " rand"},     if_rand.board_out,        SEED_RAND);
    endtask

    initial begin
        int busy_n;
        int done_n;
        logic [63:0] exp_corner;
        seeds[0] = SEED_BLINK;
        seeds[1] = SEED_BLOCK;
        seeds[2] = SEED_CORNER;
        seeds[3] = SEED_RAND;
        reset_models();

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_idle_a("reset");
        chk("reset pace board", if_pace.board_out, SEED_BLINK);
        chk("reset pace busy",  64'(if_pace.busy), 64'd0);

        gen_a_step("blinker gen1", 1'b1, 0);
        chk("blinker vertical", if_blink.board_out, 64'h0000_0008_0808_0000);
        gen_a_step("blinker gen2", 1'b1, 0);
        chk("blinker horizontal", if_blink.board_out, SEED_BLINK);
        chk("blinker generation", 64'(if_blink.generation), 64'd2);

        for (int g = 3; g <= 10; g++) gen_a_step("still life", 1'b1, 0);
        chk("block constant", if_block.board_out, SEED_BLOCK);
        chk("block generation", 64'(if_block.generation), 64'd10);
`ifdef LIFE_TORUS_EN
        exp_corner = SEED_CORNER;
`else
        exp_corner = 64'd0;
`endif
        chk("corner edges", if_corner.board_out, exp_corner);

        for (int i = 0; i < 16; i++) begin
            bit r;
            int extra;
            r = ($urandom % 4) != 0;
            extra = (r && ($urandom % 2 == 1)) ? int'($urandom_range(5, 60)) : 0;
            repeat ($urandom % 7) step();
            gen_a_step("random", r, extra);
        end

        run_a = 1'b1;
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        repeat (20) step();
        chk("pre-clear busy", 64'(if_blink.busy), 64'd1);
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        check_idle_a("clear mid-scan");
        reset_models();
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 70; k++) begin
            if (if_blink.busy) busy_n++;
            if (if_blink.gen_done || if_rand.gen_done) done_n++;
            step();
        end
        chk("post-clear busy", 64'(busy_n), 64'd0);
        chk("post-clear gen_done", 64'(done_n), 64'd0);
        check_boards("post-clear");

        tick_a = 1'b1;
        clear_a = 1'b1;
        step();
        tick_a = 1'b0;
        clear_a = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 70; k++) begin
            if (if_blink.busy) busy_n++;
            step();
        end
        chk("clear+tick no scan", 64'(busy_n), 64'd0);
        check_boards("clear+tick");

        pace_ticks(1'b1, 180, 60);
        chk("pace 180 dones", 64'(p_dones), 64'd3);
        chk("pace generation", 64'(if_pace.generation), 64'd3);
        pace_ticks(1'b1, 30, 0);
        pace_ticks(1'b0, 100, 0);
        pace_ticks(1'b1, 29, 0);
        chk("pace held count", 64'(p_dones), 64'd3);
        pace_ticks(1'b1, 1, 1);
        chk("pace resumed", 64'(p_dones), 64'd4);
        chk("pace misplaced", 64'(p_misplaced), 64'd0);

        run_a = 1'b1;
        tick_a = 1'b1;
        step();
        tick_a = 1'b0;
        repeat (30) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_a("reset mid-scan");
        chk("reset pace gen", 64'(if_pace.generation), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
